program_loader: RTL and testbench

//  Upstream stage of the multi-cycle 16-bit MIPS core: receives a program as a byte stream
//  (valid/ready), assembles 16-bit instruction words and writes them into the core's

---
 rtl/loader_pkg.sv | 17 +
 rtl/loader_word_assembler.sv | 43 ++++
 rtl/program_loader.sv | 108 ++++++++++
 tb/tb_program_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and widths for the program loader.
// The optional checksum trailer is enabled with the LOADER_CHECKSUM_EN macro.
package loader_pkg;
    localparam int WORD_W          = 16;
    localparam int BYTE_W          = 8;
    localparam int IMEM_WORDS_DEF  = 100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_WRITE,
        S_CHK,
        S_RUN,
        S_ERR
    } state_t;
endpackage

// File: rtl/loader_word_assembler.sv
// Captures high/low stream bytes into one instruction word.
// With LOADER_CHECKSUM_EN, it also keeps a running XOR of every data byte.
import loader_pkg::*;

module loader_word_assembler (
    input  logic              clk,
    input  logic              reset,
    input  logic              hi_en,
    input  logic              lo_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word
`ifdef LOADER_CHECKSUM_EN
    ,
    input  logic              clr,
    output logic              csum_match
`endif
);
    logic [BYTE_W-1:0] hi_q, lo_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (hi_en) hi_q <= byte_in;
            if (lo_en) lo_q <= byte_in;
        end
    end

    assign word = {hi_q, lo_q};

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] xor_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)               xor_q <= '0;
        else if (clr)            xor_q <= '0;
        else if (hi_en || lo_en) xor_q <= xor_q ^ byte_in;
    end

    assign csum_match = (xor_q == byte_in);
`endif
endmodule

// File: rtl/program_loader.sv
// Streams a count-prefixed program image into instruction memory and holds the core in reset until done.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
import loader_pkg::*;

module program_loader #(
    parameter logic [WORD_W-1:0] BASE_ADDR  = '0,
    parameter int                IMEM_WORDS = IMEM_WORDS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic              reload,
    output logic              instruction_write_en,
    output logic [WORD_W-1:0] write_instruction_address,
    output logic [WORD_W-1:0] write_instruction,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);
`ifdef LOADER_CHECKSUM_EN
    localparam state_t AFTER_LAST = S_CHK;
    logic csum_match;
`else
    localparam state_t AFTER_LAST = S_RUN;
`endif

    state_t            state_q, state_d;
    logic [BYTE_W-1:0] cnt_q, idx_q;
    logic              accept;
    logic              wr_en_d, cpu_reset_d, done_d, error_d;

    assign byte_ready = !reset && (state_q inside {S_IDLE, S_HI, S_LO, S_CHK});
    assign accept     = byte_valid && byte_ready;

    loader_word_assembler u_asm (
        .clk     (clk),
        .reset   (reset),
        .hi_en   (accept && state_q == S_HI),
        .lo_en   (accept && state_q == S_LO),
        .byte_in (byte_in),
        .word    (write_instruction)
`ifdef LOADER_CHECKSUM_EN
        ,
        .clr       (state_q == S_IDLE),
        .csum_match(csum_match)
`endif
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept)
                        state_d = (byte_in == '0 || int'(byte_in) > IMEM_WORDS) ? S_ERR : S_HI;
            S_HI:    if (accept) state_d = S_LO;
            S_LO:    if (accept) state_d = S_WRITE;
            S_WRITE: state_d = (idx_q + 8'd1 == cnt_q) ? AFTER_LAST : S_HI;
`ifdef LOADER_CHECKSUM_EN
            S_CHK:   if (accept) state_d = csum_match ? S_RUN : S_ERR;
`endif
            S_RUN, S_ERR: if (reload) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with the state.
    always_comb begin
        wr_en_d     = (state_d == S_WRITE);
        cpu_reset_d = (state_d != S_RUN);
        done_d      = (state_d == S_RUN);
        error_d     = (state_d == S_ERR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instruction_write_en      <= 1'b0;
            write_instruction_address <= BASE_ADDR;
            cpu_reset                 <= 1'b1;
            done                      <= 1'b0;
            error                     <= 1'b0;
        end else begin
            instruction_write_en <= wr_en_d;
            cpu_reset            <= cpu_reset_d;
            done                 <= done_d;
            error                <= error_d;
            if (state_d == S_WRITE)
                write_instruction_address <= BASE_ADDR + {{(WORD_W-BYTE_W){1'b0}}, idx_q};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (state_q == S_IDLE && accept) begin
            cnt_q <= byte_in;
            idx_q <= '0;
        end else if (state_q == S_WRITE) begin
            idx_q <= idx_q + 8'd1;
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: a write scoreboard plus a memory image model.
// Status is checked after every frame; build with LOADER_CHECKSUM_EN to exercise trailers.
module tb_program_loader;
    localparam logic [15:0] BASE = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        reload;
    logic        instruction_write_en;
    logic [15:0] write_instruction_address;
    logic [15:0] write_instruction;
    logic        cpu_reset;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    program_loader #(.BASE_ADDR(BASE), .IMEM_WORDS(100)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .byte_in                  (byte_in),
        .byte_valid               (byte_valid),
        .byte_ready               (byte_ready),
        .reload                   (reload),
        .instruction_write_en     (instruction_write_en),
        .write_instruction_address(write_instruction_address),
        .write_instruction        (write_instruction),
        .cpu_reset                (cpu_reset),
        .done                     (done),
        .error                    (error)
    );

    typedef struct packed { logic [15:0] a; logic [15:0] d; } wr_t;

    int          total = 0;
    int          bad   = 0;
    wr_t         expq[$];
    wr_t         e_cmp;
    logic [15:0] img       [0:127];
    int          img_n;
    logic [15:0] model_mem [0:127];
    logic [15:0] dut_mem   [0:127];
    logic        prev_wr = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Per-cycle compare: reset values, strobe scoreboard, and status invariants.
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_ready", byte_ready, 0);
            chk("rst_wr_en", instruction_write_en, 0);
            chk("rst_addr", write_instruction_address, BASE);
            chk("rst_data", write_instruction, 0);
            chk("rst_cpu_reset", cpu_reset, 1);
            chk("rst_done", done, 0);
            chk("rst_error", error, 0);
        end else begin
            chk("cpu_reset_vs_done", cpu_reset, !done);
            chk("done_error_excl", done & error, 0);
            if (instruction_write_en) begin
                chk("ready_in_write", byte_ready, 0);
                chk("strobe_one_cycle", prev_wr, 0);
                chk("core_held_in_write", cpu_reset, 1);
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL stray_strobe: got addr %0h data %0h want no strobe",
                             write_instruction_address, write_instruction);
                end else begin
                    e_cmp = expq.pop_front();
                    if (write_instruction_address !== e_cmp.a || write_instruction !== e_cmp.d) begin
                        bad++;
                        $display("FAIL strobe: got %0h/%0h want %0h/%0h", write_instruction_address,
                                 write_instruction, e_cmp.a, e_cmp.d);
                    end
                end
                dut_mem[write_instruction_address[6:0]] = write_instruction;
            end
        end
        prev_wr <= instruction_write_en;
    end

    function automatic int pick_gap(input int gmode);
        if (gmode == 0) return 0;
        if (gmode == 1) return 1;
        return int'($urandom_range(0, 2));
    endfunction

    // Offers a byte and returns at the negedge following the edge that consumed it.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_in    = b;
        byte_valid = 1'b1;
        n = 0;
        while (!byte_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) chk("byte_timeout", byte_ready, 1);
        @(negedge clk);
    endtask

    task automatic send_image(input int gmode, input bit badc);
        logic [7:0] cs;
        cs = 8'h00;
        for (int i = 0; i < img_n; i++) begin
            expq.push_back('{a: BASE + 16'(i), d: img[i]});
            model_mem[i] = img[i];
            cs = cs ^ img[i][15:8] ^ img[i][7:0];
        end
        send_byte(8'(img_n), pick_gap(gmode));
        for (int i = 0; i < img_n; i++) begin
            send_byte(img[i][15:8], pick_gap(gmode));
            send_byte(img[i][7:0], pick_gap(gmode));
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(badc ? (cs ^ 8'h01) : cs, pick_gap(gmode));
        byte_valid = 1'b0;
        chk("csum_done", done, !badc);
        chk("csum_error", error, badc);
        chk("csum_cpu_reset", cpu_reset, badc);
`else
        byte_valid = 1'b0;
        chk("last_write_en", instruction_write_en, 1);
        chk("pre_run_done", done, 0);
        @(negedge clk);
        chk("run_done", done, 1);
        chk("run_cpu_reset", cpu_reset, 0);
        chk("run_error", error, badc);
`endif
        chk("queue_drained", expq.size(), 0);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("reload_cpu_reset", cpu_reset, 1);
        chk("reload_done", done, 0);
        chk("reload_error", error, 0);
    endtask

    task automatic send_bad_count(input logic [7:0] n);
        send_byte(n, 0);
        byte_valid = 1'b0;
        chk("badcnt_error", error, 1);
        chk("badcnt_cpu_reset", cpu_reset, 1);
        chk("badcnt_done", done, 0);
    endtask

    initial begin
        reset      = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        reload     = 1'b0;
        for (int i = 0; i < 128; i++) begin
            model_mem[i] = 16'h0;
            dut_mem[i]   = 16'h0;
        end
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);

        // Three-word image, continuous valid
        img[0] = 16'h1234; img[1] = 16'hC004; img[2] = 16'h2005; img_n = 3;
        send_image(0, 1'b0);
        chk("t1_addr_lit", write_instruction_address, 16'd2);
        chk("t1_data_lit", write_instruction, 16'h2005);
        do_reload();

        // Illegal counts; stream ignored while in ERR
        send_bad_count(8'd0);
        byte_in    = 8'h05;
        byte_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("err_ready", byte_ready, 0);
            chk("err_hold", error, 1);
        end
        byte_valid = 1'b0;
        do_reload();
        send_bad_count(8'd101);
        do_reload();

        // Same image with valid gaps between every byte
        img[0] = 16'h1234; img[1] = 16'hC004; img[2] = 16'h2005; img_n = 3;
        send_image(1, 1'b0);
        do_reload();

        // Reset after the first word of a two-word image
        expq.push_back('{a: BASE, d: 16'h1122});
        model_mem[0] = 16'h1122;
        send_byte(8'd2, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        byte_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_wr_en", instruction_write_en, 0);
        chk("midrst_addr", write_instruction_address, BASE);
        chk("midrst_cpu_reset", cpu_reset, 1);
        chk("midrst_ready", byte_ready, 0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        img[0] = 16'hABCD; img_n = 1;
        send_image(0, 1'b0);
        do_reload();

`ifdef LOADER_CHECKSUM_EN
        // Trailer 8'h04 matches, 8'h05 does not
        img[0] = 16'h0102; img[1] = 16'h0304; img_n = 2;
        send_image(0, 1'b0);
        do_reload();
        send_image(0, 1'b1);
        do_reload();
`endif

        // Random images, reloaded from RUN/ERR; the last one fills memory exactly
        for (int k = 0; k < 6; k++) begin
            img_n = (k == 5) ? 100 : int'($urandom_range(1, 8));
            for (int i = 0; i < img_n; i++) img[i] = 16'($urandom);
`ifdef LOADER_CHECKSUM_EN
            send_image(2, 1'($urandom_range(0, 1)));
`else
            send_image(2, 1'b0);
`endif
            do_reload();
        end

        for (int i = 0; i < 100; i++) begin
            if (dut_mem[i] !== model_mem[i]) chk("mem_image", dut_mem[i], model_mem[i]);
        end
        chk("mem_word0", dut_mem[0], model_mem[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
